control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Upstream stage of the 8-bit Datapath: it generates the 16-bit control word that the Datapath consumes.
- Steps through a fixed four-entry micro-program: load R0, load R1, R2=R1+R0, MOVB R2.
- Each word is issued for exactly one clock with RW=1. Between issues it drives a NOP word with RW=0, so the register file is never written twice.
- Runs in single-step mode (one word per start press) or run mode (back-to-back words). Exports step index, busy, done and an issue counter for the 7-seg/LED front panel.

Parameters:
- NUM_STEPS, 4, number of ROM entries executed (1..4); entries 0..NUM_STEPS-1 are used.
- STEP_W, 2, width of the step index output.
- CNT_W, 8, width of the saturating issue counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse from the debounce block.
- run_mode  input  1  0 = single-step, 1 = run to end.
- control_word  output  16  {DA[15:13], AA[12:10], BA[9:7], MB[6], FS[5:2], MD[1], RW[0]} to the Datapath.
- word_valid  output  1  high in the cycle a ROM word (RW=1) is driven.
- step  output  STEP_W  index of the current/last issued ROM entry.
- busy  output  1  high in ISSUE and HOLD.
- done  output  1  high in DONE.
- issue_count  output  CNT_W  total words issued since reset; saturates at all-ones.

Behaviour:
- ROM contents (fixed):
  - [0] = 16'h0003: DA=R0, MOVA, MD=1, RW=1.
  - [1] = 16'h2483: DA=AA=BA=R1, MD=1, RW=1.
  - [2] = 16'h4409: DA=R2, AA=R1, BA=R0, FS=0010 ADD, MD=0, RW=1.
  - [3] = 16'h4131: DA=R2, BA=R2, FS=1100 MOVB, MD=0, RW=1.
- NOP word = 16'h0000.
- Reset (reset=0, asynchronous, immediate on assertion):
  - State = IDLE; control_word = 0x0000; word_valid = 0; step = 0; busy = 0; done = 0; issue_count = 0.
  - Reset mid-program aborts at once; no partial word remains on control_word.
- States: IDLE, ISSUE, HOLD, DONE.
- All outputs are registered: a word appears on the cycle after the triggering start or transition, i.e. latency 1 clock.
- IDLE:
  - Outputs NOP.
  - start=1 -> ISSUE with step=0.
- ISSUE (one cycle):
  - control_word = ROM[step]; word_valid = 1; issue_count += 1, saturating at 255.
  - Then:
    - if step == NUM_STEPS-1 -> DONE;
    - else if run_mode == 1 -> ISSUE with step+1;
    - else -> HOLD.
- HOLD:
  - control_word = NOP; word_valid = 0; step keeps the last issued index.
  - start=1 -> ISSUE with step+1.
- DONE:
  - control_word = NOP; done = 1; step = NUM_STEPS-1.
  - start=1 -> ISSUE with step=0; done drops in the same cycle the word is issued.
- start arriving in an ISSUE cycle is ignored, in both modes; it is not queued.
- run_mode is sampled only at the end of each ISSUE cycle. Toggling it during HOLD has no effect until the next ISSUE.
- Switching from step mode to run mode during HOLD: the next start issues the remaining words back-to-back.
- NUM_STEPS=1: ISSUE goes straight to DONE after ROM[0].
- word_valid is exactly equal to control_word[0] in every cycle.

Test Plan:
1. Reset value: hold reset=0, then release -> control_word=0x0000, step=0, busy=0, done=0, issue_count=0. Pulse reset=0 mid-ISSUE -> outputs return to these values before the next clk edge.
2. Run mode: run_mode=1, one start pulse at cycle 0:
   - cycles 1..4 show 0x0003, 0x2483, 0x4409, 0x4131 with word_valid=1;
   - cycle 5: done=1, control_word=0x0000, issue_count=4.
3. Single-step mode: run_mode=0, four start pulses spaced 5 cycles apart:
   - each pulse yields exactly one RW=1 cycle, with NOP and step stable between pulses;
   - done=1 after the 4th pulse.
4. Ignored start: run_mode=1, start pulsed again during cycle 2 of the burst -> sequence unchanged, no extra issue, issue_count=4.
5. Restart and saturation:
   - start in DONE -> 0x0003 issued next cycle, done=0;
   - run 64 full programs -> issue_count saturates at 255, no wrap to 0.
6. Mode switch: run_mode=0, one start, then set run_mode=1 during HOLD and pulse start -> 0x2483, 0x4409, 0x4131 on consecutive cycles, then DONE.

Source files
------------

// File: rtl/control_sequencer.sv
// Four-entry micro-program sequencer feeding the 8-bit datapath with one RW=1 word per issue.
// Latency: 1 clock from start or transition to word. No backpressure; start during ISSUE is dropped.
module control_sequencer #(
    parameter int NUM_STEPS = 4,
    parameter int STEP_W    = 2,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              run_mode,
    output logic [15:0]       control_word,
    output logic              word_valid,
    output logic [STEP_W-1:0] step,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  issue_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DONE} state_t;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [15:0]       NOP_WORD  = 16'h0000;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [15:0]         cw_q, cw_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                issue_now;

    function automatic logic [15:0] rom_word(input logic [STEP_W-1:0] idx);
        logic [15:0] w;
        case (int'(idx))
            0:       w = 16'h0003;
            1:       w = 16'h2483;
            2:       w = 16'h4409;
            3:       w = 16'h4131;
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ISSUE;
                    step_d  = '0;
                end
            end
            ISSUE: begin
                // start is ignored here; only run_mode decides what follows an issue
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end else if (run_mode) begin
                    state_d = ISSUE;
                    step_d  = step_q + 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (start) begin
                    state_d = ISSUE;
                    step_d  = step_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from the next state so they register alongside it.
        issue_now = (state_d == ISSUE);
        cw_d      = issue_now ? rom_word(step_d) : NOP_WORD;
        cnt_d     = (issue_now && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        busy_d    = (state_d == ISSUE) || (state_d == HOLD);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            cw_q    <= NOP_WORD;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cw_q    <= cw_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign control_word = cw_q;
    assign word_valid   = cw_q[0];
    assign step         = step_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign issue_count  = cnt_q;

endmodule
